// File: rtl/cpu_mem_bridge_if.sv
`timescale 1ns/1ps
// cpu_mem_bridge_if
// Request/data bundle between the CPU bridge and port 1 of the dual-port
// SRAM arbiter. The bridge is the master: it drives address, strobes and
// write data, and the arbiter returns read data on dout1.
interface cpu_mem_bridge_if;
   logic [18:0] a1;
   logic        oe1_n;
   logic        we1_n;
   logic [7:0]  din1;
   logic [7:0]  dout1;

   modport master (output a1, oe1_n, we1_n, din1, input dout1);
   modport slave  (input a1, oe1_n, we1_n, din1, output dout1);
endinterface

// File: rtl/cpu_mem_bridge.sv
`timescale 1ns/1ps
// cpu_mem_bridge
// CPU-side stage for port 1 of the 28 MHz dual-port SRAM arbiter. It
// synchronises the asynchronous Z80 MREQ/RD/WR strobes and turns each memory
// stroke into exactly one fixed-length request: a write holds we1_n low for
// WR_CYCLES clocks, and a read holds oe1_n low for RD_CYCLES clocks before
// capturing dout1 into cpu_dout.
//
// Optional feature: define ROM_WRITE_PROTECT_EN to suppress the we1_n pulse
// for writes below 64 KB while rom_wp is high. The write still takes its
// full hold time so the CPU-visible timing is unchanged.
module cpu_mem_bridge #(
   parameter int WR_CYCLES = 6,
   parameter int RD_CYCLES = 7,
   parameter int CNT_W     = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [18:0]      cpu_a,
   input  logic             cpu_mreq_n,
   input  logic             cpu_rd_n,
   input  logic             cpu_wr_n,
   input  logic [7:0]       cpu_din,
   output logic [7:0]       cpu_dout,
   input  logic             rom_wp,
   output logic             busy,
   cpu_mem_bridge_if.master port1
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WR_HOLD  = 2'd1,
      RD_HOLD  = 2'd2,
      WAIT_REL = 2'd3
   } state_t;

   // Terminal counts; the counter stops at these values and never wraps.
   localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(WR_CYCLES - 1);
   localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(RD_CYCLES - 1);

   state_t           state;
   logic [CNT_W-1:0] cnt;

   logic [1:0] mreq_sync;
   logic [1:0] rd_sync;
   logic [1:0] wr_sync;
   logic       rd_req;
   logic       wr_req;
   logic       wr_blocked;

   // Two-stage synchronisers for the Z80 strobes; idle (high) out of reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         mreq_sync <= 2'b11;
         rd_sync   <= 2'b11;
         wr_sync   <= 2'b11;
      end else begin
         // NOTE: non-blocking so each stage takes the previous stage's old value; blocking would collapse the chain into one flop.
         mreq_sync <= {mreq_sync[0], cpu_mreq_n};
         rd_sync   <= {rd_sync[0],   cpu_rd_n};
         wr_sync   <= {wr_sync[0],   cpu_wr_n};
      end
   end

   assign rd_req = ~mreq_sync[1] & ~rd_sync[1];
   assign wr_req = ~mreq_sync[1] & ~wr_sync[1];

`ifdef ROM_WRITE_PROTECT_EN
   // Writes into the lowest 64 KB are dropped while the ROM is protected.
   assign wr_blocked = rom_wp & (cpu_a[18:16] == 3'b000);
`else
   logic rom_wp_unused;
   assign rom_wp_unused = rom_wp;
   assign wr_blocked    = 1'b0;
`endif

   // Stroke sequencer: one fixed-length arbiter request per CPU stroke.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         cnt         <= '0;
         busy        <= 1'b0;
         cpu_dout    <= 8'hFF;
         port1.a1    <= '0;
         port1.din1  <= '0;
         port1.we1_n <= 1'b1;
         port1.oe1_n <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               // A write wins if both strobes appear together.
               if (wr_req) begin
                  port1.a1    <= cpu_a;
                  port1.din1  <= cpu_din;
                  port1.we1_n <= wr_blocked;
                  busy        <= 1'b1;
                  cnt         <= '0;
                  state       <= WR_HOLD;
               end else if (rd_req) begin
                  port1.a1    <= cpu_a;
                  port1.oe1_n <= 1'b0;
                  busy        <= 1'b1;
                  cnt         <= '0;
                  state       <= RD_HOLD;
               end
            end

            WR_HOLD: begin
               // Pulse length is fixed, independent of when WR is released.
               if (cnt == WR_LAST) begin
                  port1.we1_n <= 1'b1;
                  cnt         <= '0;
                  state       <= WAIT_REL;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

            RD_HOLD: begin
               // dout1 is only valid while oe1_n is low, so capture on the
               // same edge that releases it.
               if (cnt == RD_LAST) begin
                  cpu_dout    <= port1.dout1;
                  port1.oe1_n <= 1'b1;
                  cnt         <= '0;
                  state       <= WAIT_REL;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

            WAIT_REL: begin
               // Wait for the CPU to end its stroke so it is not served twice.
               busy <= 1'b0;
               if (!rd_req && !wr_req) begin
                  state <= IDLE;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cpu_mem_bridge.sv
`timescale 1ns/1ps
// tb_cpu_mem_bridge
// Directed bench for cpu_mem_bridge: a table of CPU strokes with
// hand-computed pulse lengths and captured values, plus hand-written
// sequences for reset and reset in the middle of a write.
module tb_cpu_mem_bridge;

   logic        clk;
   logic        rst;
   logic [18:0] cpu_a;
   logic        cpu_mreq_n;
   logic        cpu_rd_n;
   logic        cpu_wr_n;
   logic [7:0]  cpu_din;
   logic [7:0]  cpu_dout;
   logic        rom_wp;
   logic        busy;

   cpu_mem_bridge_if bus ();

   cpu_mem_bridge dut (
      .clk        (clk),
      .rst        (rst),
      .cpu_a      (cpu_a),
      .cpu_mreq_n (cpu_mreq_n),
      .cpu_rd_n   (cpu_rd_n),
      .cpu_wr_n   (cpu_wr_n),
      .cpu_din    (cpu_din),
      .cpu_dout   (cpu_dout),
      .rom_wp     (rom_wp),
      .busy       (busy),
      .port1      (bus)
   );

   // 28 MHz-ish clock (36 ns period).
   initial clk = 1'b0;
   always #18 clk = ~clk;

   // Memory model: fixed pattern, with one known word at 19'h05123.
   function automatic logic [7:0] mem_rd(input logic [18:0] a);
      if (a == 19'h05123) return 8'h3C;
      return a[7:0] ^ 8'h55;
   endfunction

   assign bus.dout1 = bus.oe1_n ? 8'h00 : mem_rd(bus.a1);

   // Cumulative observations taken on the falling edge.
   int         we_pulses = 0;
   int         we_low    = 0;
   int         oe_pulses = 0;
   int         oe_low    = 0;
   logic       we_prev   = 1'b1;
   logic       oe_prev   = 1'b1;
   logic [7:0] dout_last_low = 8'h00;
   logic [7:0] dout_at_rise  = 8'h00;

   always @(negedge clk) begin
      if (bus.we1_n === 1'b0) we_low <= we_low + 1;
      if (bus.we1_n === 1'b0 && we_prev === 1'b1) we_pulses <= we_pulses + 1;
      if (bus.oe1_n === 1'b0) begin
         oe_low        <= oe_low + 1;
         dout_last_low <= cpu_dout;
      end
      if (bus.oe1_n === 1'b0 && oe_prev === 1'b1) oe_pulses <= oe_pulses + 1;
      if (bus.oe1_n === 1'b1 && oe_prev === 1'b0) dout_at_rise <= cpu_dout;
      we_prev <= bus.we1_n;
      oe_prev <= bus.oe1_n;
   end

   int tests = 0;
   int fails = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic timeout(input string name);
      tests++;
      fails++;
      $display("FAIL %s: timed out waiting for DUT", name);
   endtask

   // Wait (bounded) for busy to drop, then let the FSM settle back to IDLE.
   task automatic wait_idle(input string name);
      int n = 0;
      while (busy !== 1'b0 && n < 60) begin
         @(negedge clk);
         n++;
      end
      if (busy !== 1'b0) timeout(name);
      repeat (6) @(negedge clk);
   endtask

   typedef enum logic [1:0] {K_RD, K_WR, K_BOTH} kind_t;

   typedef struct {
      string       name;
      kind_t       kind;
      logic [18:0] addr;
      logic [7:0]  data;
      logic        wp;
      int          hold_ns;
      int          exp_we_pulses;
      int          exp_we_low;
      int          exp_oe_pulses;
      int          exp_oe_low;
      logic [18:0] exp_a1;
      logic [7:0]  exp_din1;
      logic [7:0]  exp_dout;
   } vec_t;

   localparam int NV = 9;
   vec_t vecs[NV];

`ifdef ROM_WRITE_PROTECT_EN
   localparam int WP_PULSES = 0;
   localparam int WP_LOW    = 0;
`else
   localparam int WP_PULSES = 1;
   localparam int WP_LOW    = 6;
`endif

   task automatic run_vec(input vec_t v, input logic [7:0] prev_dout);
      int wp0, wl0, op0, ol0;
      @(negedge clk);
      wp0 = we_pulses; wl0 = we_low; op0 = oe_pulses; ol0 = oe_low;
      cpu_a      = v.addr;
      cpu_din    = v.data;
      rom_wp     = v.wp;
      cpu_mreq_n = 1'b0;
      cpu_rd_n   = (v.kind == K_WR)  ? 1'b1 : 1'b0;
      cpu_wr_n   = (v.kind == K_RD)  ? 1'b1 : 1'b0;
      #(v.hold_ns);
      cpu_mreq_n = 1'b1;
      cpu_rd_n   = 1'b1;
      cpu_wr_n   = 1'b1;
      wait_idle({v.name, ".idle"});
      check({v.name, ".we_pulses"}, we_pulses - wp0, v.exp_we_pulses);
      check({v.name, ".we_low"},    we_low - wl0,    v.exp_we_low);
      check({v.name, ".oe_pulses"}, oe_pulses - op0, v.exp_oe_pulses);
      check({v.name, ".oe_low"},    oe_low - ol0,    v.exp_oe_low);
      check({v.name, ".a1"},        bus.a1,          v.exp_a1);
      check({v.name, ".din1"},      bus.din1,        v.exp_din1);
      check({v.name, ".cpu_dout"},  cpu_dout,        v.exp_dout);
      check({v.name, ".we1_n"},     bus.we1_n,       1);
      check({v.name, ".oe1_n"},     bus.oe1_n,       1);
      if (v.kind == K_RD) begin
         check({v.name, ".dout_before_edge"}, dout_last_low, prev_dout);
         check({v.name, ".dout_at_edge"},     dout_at_rise,  v.exp_dout);
      end
   endtask

   initial begin
      int wp0, wl0, n;
      logic [7:0] prev_dout;

      //           name               kind    addr       data   wp    ns   weP weL      oeP oeL a1         din1   dout
      vecs[0] = '{"read_05123",      K_RD,   19'h05123, 8'h00, 1'b0, 300, 0,  0,       1,  7,  19'h05123, 8'h00, 8'h3C};
      vecs[1] = '{"write_1c000",     K_WR,   19'h1C000, 8'hA5, 1'b0, 300, 1,  6,       0,  0,  19'h1C000, 8'hA5, 8'h3C};
      vecs[2] = '{"short_write",     K_WR,   19'h2ABCD, 8'h5A, 1'b0, 150, 1,  6,       0,  0,  19'h2ABCD, 8'h5A, 8'h3C};
      vecs[3] = '{"read_7ffff",      K_RD,   19'h7FFFF, 8'h00, 1'b0, 300, 0,  0,       1,  7,  19'h7FFFF, 8'h5A, 8'hAA};
      vecs[4] = '{"short_read_zero", K_RD,   19'h00000, 8'h00, 1'b0, 150, 0,  0,       1,  7,  19'h00000, 8'h5A, 8'h55};
      vecs[5] = '{"wp_below_64k",    K_WR,   19'h00010, 8'h11, 1'b1, 300, WP_PULSES, WP_LOW, 0, 0, 19'h00010, 8'h11, 8'h55};
      vecs[6] = '{"wp_above_64k",    K_WR,   19'h10010, 8'h22, 1'b1, 300, 1,  6,       0,  0,  19'h10010, 8'h22, 8'h55};
      vecs[7] = '{"both_write_wins", K_BOTH, 19'h3F00F, 8'h77, 1'b0, 300, 1,  6,       0,  0,  19'h3F00F, 8'h77, 8'h55};
      vecs[8] = '{"read_again",      K_RD,   19'h05123, 8'h00, 1'b0, 300, 0,  0,       1,  7,  19'h05123, 8'h77, 8'h3C};

      // Reset: hold rst for two clocks with the CPU idle.
      rst        = 1'b1;
      cpu_a      = '0;
      cpu_din    = '0;
      cpu_mreq_n = 1'b1;
      cpu_rd_n   = 1'b1;
      cpu_wr_n   = 1'b1;
      rom_wp     = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset.we1_n",    bus.we1_n, 1);
      check("reset.oe1_n",    bus.oe1_n, 1);
      check("reset.busy",     busy,      0);
      check("reset.cpu_dout", cpu_dout,  8'hFF);
      check("reset.a1",       bus.a1,    0);
      check("reset.din1",     bus.din1,  0);
      rst = 1'b0;
      repeat (3) @(negedge clk);

      prev_dout = 8'hFF;
      for (int i = 0; i < NV; i++) begin
         run_vec(vecs[i], prev_dout);
         prev_dout = vecs[i].exp_dout;
      end

      // Reset during the third clock of a write, WR held throughout.
      @(negedge clk);
      rom_wp     = 1'b0;
      cpu_a      = 19'h1C000;
      cpu_din    = 8'hA5;
      cpu_mreq_n = 1'b0;
      cpu_wr_n   = 1'b0;
      n = 0;
      while (bus.we1_n !== 1'b0 && n < 10) begin
         @(negedge clk);
         n++;
      end
      if (bus.we1_n !== 1'b0) timeout("midrst.first_pulse");
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("midrst.we1_n", bus.we1_n, 1);
      check("midrst.busy",  busy,      0);
      check("midrst.a1",    bus.a1,    0);
      rst = 1'b0;
      wp0 = we_pulses;
      wl0 = we_low;
      n = 0;
      while (bus.we1_n !== 1'b0 && n < 10) begin
         @(negedge clk);
         n++;
      end
      if (bus.we1_n !== 1'b0) timeout("midrst.fresh_pulse");
      n = 0;
      while (bus.we1_n === 1'b0 && n < 20) begin
         @(negedge clk);
         n++;
      end
      cpu_mreq_n = 1'b1;
      cpu_wr_n   = 1'b1;
      wait_idle("midrst.idle");
      check("midrst.we_pulses", we_pulses - wp0, 1);
      check("midrst.we_low",    we_low - wl0,    6);
      check("midrst.a1_after",  bus.a1,          19'h1C000);
      check("midrst.din1",      bus.din1,        8'hA5);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
